// File: rtl/cmp_sched_pkg.sv
// Shared types and sizing helpers for the comparator batch scheduler.
package cmp_sched_pkg;

  localparam logic [1:0] EncIdle    = 2'd0;
  localparam logic [1:0] EncLoad    = 2'd1;
  localparam logic [1:0] EncCompare = 2'd2;
  localparam logic [1:0] EncDrain   = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = EncIdle,
    StLoad    = EncLoad,
    StCompare = EncCompare,
    StDrain   = EncDrain
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cmp_sched_ctr.sv
// Wrap counter: counts 0..MaxVal on en, wraps to 0, clear has priority.
module cmp_sched_ctr #(
  parameter int unsigned MaxVal = 7,
  parameter int unsigned Width  = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  output logic [Width-1:0] cnt,
  output logic             wrap
);

  logic [Width-1:0] cnt_q;

  assign cnt  = cnt_q;
  assign wrap = en && (cnt_q == Width'(MaxVal));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr || wrap) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

endmodule

// File: rtl/cmp_sched.sv
// Batch scheduler: first UNIT_NO vectors load the units as references, the
// rest are broadcast as queries until batch-last, then drain.
module cmp_sched
  import cmp_sched_pkg::*;
#(
  parameter int unsigned BUS_WIDTH    = 128,
  parameter int unsigned VECTOR_WIDTH = 920,
  parameter int unsigned VEC_ID_WIDTH = 8,
  parameter int unsigned UNIT_NO      = 4,
  parameter int unsigned SUB_VEC_NO   = ceil_div(VECTOR_WIDTH, BUS_WIDTH),
  localparam int unsigned SubW        = idx_width(SUB_VEC_NO),
  localparam int unsigned UnitW       = idx_width(UNIT_NO),
  localparam int unsigned CntW        = cnt_width(UNIT_NO)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [BUS_WIDTH-1:0]    up_Vector,
  input  logic [VEC_ID_WIDTH-1:0] up_VecID,
  input  logic                    up_Valid,
  input  logic                    up_Last,
  output logic                    up_Ready,
  output logic [BUS_WIDTH-1:0]    ref_Vector,
  output logic [SubW-1:0]         ref_SubIdx,
  output logic [UNIT_NO-1:0]      ref_WrEn,
  output logic [BUS_WIDTH-1:0]    cmp_Vector,
  output logic [VEC_ID_WIDTH-1:0] cmp_VecID,
  output logic                    cmp_Valid,
  output logic                    cmp_Last,
  input  logic [UNIT_NO-1:0]      cmp_Ready,
  output logic [CntW-1:0]         ref_Cnt,
  output logic                    batch_Done,
  output logic                    busy
);

  state_e           state_q;
  logic [SubW-1:0]  sub_cnt;
  logic [UnitW-1:0] unit_sel;
  logic             sub_wrap, unit_wrap;
  logic             all_ready, accept, load_beat, vec_end, batch_end;

  assign all_ready = &cmp_Ready;
  assign up_Ready  = (state_q == StCompare) ? all_ready : (state_q != StDrain);
  assign accept    = up_Valid && up_Ready;
  // The IDLE beat is the first reference beat of the batch.
  assign load_beat = accept && ((state_q == StIdle) || (state_q == StLoad));
  assign batch_end = accept && up_Last;
  assign vec_end   = sub_wrap || up_Last;

  assign cmp_Valid  = (state_q == StCompare) && up_Valid && all_ready;
  assign cmp_Vector = up_Vector;
  assign cmp_VecID  = up_VecID;
  assign cmp_Last   = up_Last && cmp_Valid;
  assign batch_Done = (state_q == StDrain) && all_ready;
  assign busy       = (state_q != StIdle);

  cmp_sched_ctr #(
    .MaxVal (SUB_VEC_NO - 1),
    .Width  (SubW)
  ) u_sub_ctr (
    .clk  (clk),
    .rstn (rstn),
    .en   (accept),
    .clr  (batch_end),
    .cnt  (sub_cnt),
    .wrap (sub_wrap)
  );

  cmp_sched_ctr #(
    .MaxVal (UNIT_NO - 1),
    .Width  (UnitW)
  ) u_unit_ctr (
    .clk  (clk),
    .rstn (rstn),
    .en   (load_beat && sub_wrap),
    .clr  (batch_end),
    .cnt  (unit_sel),
    .wrap (unit_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      ref_Vector <= '0;
      ref_SubIdx <= '0;
      ref_WrEn   <= '0;
      ref_Cnt    <= '0;
    end else begin
      ref_WrEn <= '0;
      if (load_beat) begin
        ref_Vector <= up_Vector;
        ref_SubIdx <= sub_cnt;
        ref_WrEn   <= UNIT_NO'(1) << unit_sel;
        if (vec_end && (ref_Cnt != CntW'(UNIT_NO))) begin
          ref_Cnt <= ref_Cnt + CntW'(1);
        end
      end
      unique case (state_q)
        StIdle, StLoad: begin
          // Batch-last wins over the final reference beat.
          if (load_beat) begin
            if (up_Last) begin
              state_q <= StDrain;
            end else if (unit_wrap) begin
              state_q <= StCompare;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StCompare: begin
          if (batch_end) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (all_ready) begin
            state_q <= StIdle;
            ref_Cnt <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sched.sv
// Directed bench for cmp_sched: inputs change on the falling edge, outputs are
// sampled 2 ns later, well before the next rising edge.
module tb_cmp_sched;

  localparam int unsigned BW = 128;
  localparam int unsigned IW = 8;
  localparam int unsigned UN = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [BW-1:0] up_Vector = '0;
  logic [IW-1:0] up_VecID = '0;
  logic          up_Valid = 1'b0;
  logic          up_Last = 1'b0;
  logic          up_Ready;
  logic [BW-1:0] ref_Vector;
  logic [2:0]    ref_SubIdx;
  logic [UN-1:0] ref_WrEn;
  logic [BW-1:0] cmp_Vector;
  logic [IW-1:0] cmp_VecID;
  logic          cmp_Valid;
  logic          cmp_Last;
  logic [UN-1:0] cmp_Ready = 4'hF;
  logic [2:0]    ref_Cnt;
  logic          batch_Done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_sched dut (
    .clk        (clk),
    .rstn       (rstn),
    .up_Vector  (up_Vector),
    .up_VecID   (up_VecID),
    .up_Valid   (up_Valid),
    .up_Last    (up_Last),
    .up_Ready   (up_Ready),
    .ref_Vector (ref_Vector),
    .ref_SubIdx (ref_SubIdx),
    .ref_WrEn   (ref_WrEn),
    .cmp_Vector (cmp_Vector),
    .cmp_VecID  (cmp_VecID),
    .cmp_Valid  (cmp_Valid),
    .cmp_Last   (cmp_Last),
    .cmp_Ready  (cmp_Ready),
    .ref_Cnt    (ref_Cnt),
    .batch_Done (batch_Done),
    .busy       (busy)
  );

  function automatic logic [BW-1:0] mk(input int v, input int s);
    return {32'(v), 32'(s), 64'hC0DE_0000_F00D_0000 ^ 64'(v * 16 + s)};
  endfunction

  task automatic set_beat(input logic vld, input int v, input int s, input logic last);
    up_Valid  = vld;
    up_Vector = vld ? mk(v, s) : '0;
    up_VecID  = 8'(v);
    up_Last   = last;
  endtask

  // Loads four full reference vectors (ids base..base+3) without checking.
  task automatic load_refs(input int base);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      set_beat(1'b1, base + i / 8, i % 8, 1'b0);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_beat(1'b0, 0, 0, 1'b0);
    cmp_Ready = 4'hF;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (ref_WrEn !== 4'h0 || ref_Vector !== '0 || ref_SubIdx !== 3'd0 || ref_Cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_ref: wren=%h sub=%0d cnt=%0d vec=%h, want all zero",
               ref_WrEn, ref_SubIdx, ref_Cnt, ref_Vector);
    end
    checks++;
    if (batch_Done !== 1'b0 || busy !== 1'b0 || up_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl: done=%b busy=%b rdy=%b, want 0 0 1", batch_Done, busy, up_Ready);
    end
    checks++;
    if (cmp_Valid !== 1'b0 || cmp_Last !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmp: valid=%b last=%b, want 0 0", cmp_Valid, cmp_Last);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // 6 vectors back to back: 32 reference beats, 16 query beats, last on beat 48.
  task automatic test_full_batch();
    int b, prev, npulse, ncmp, ecnt;
    logic done;
    logic [3:0] ew;
    b = 0; prev = -1; npulse = 0; ncmp = 0; done = 1'b0;
    cmp_Ready = 4'hF;
    for (int cyc = 0; cyc < 52; cyc++) begin
      @(negedge clk);
      if (b < 48) set_beat(1'b1, 10 + b / 8, b % 8, b == 47);
      else set_beat(1'b0, 0, 0, 1'b0);
      #2;
      ew = (prev >= 0) ? 4'(1 << (prev / 8)) : 4'h0;
      checks++;
      if (ref_WrEn !== ew) begin
        errors++;
        $display("FAIL full_wren cyc %0d: got %b want %b", cyc, ref_WrEn, ew);
      end
      if (ref_WrEn != 4'h0) npulse++;
      if (prev >= 0) begin
        checks++;
        if (ref_SubIdx !== 3'(prev % 8) || ref_Vector !== mk(10 + prev / 8, prev % 8)) begin
          errors++;
          $display("FAIL full_refdata cyc %0d: sub %0d want %0d", cyc, ref_SubIdx, prev % 8);
        end
      end
      checks++;
      if (cmp_Valid !== (b >= 32 && b < 48) || cmp_Last !== (b == 47)) begin
        errors++;
        $display("FAIL full_cmp cyc %0d: valid=%b last=%b want %b %b", cyc, cmp_Valid,
                 cmp_Last, (b >= 32 && b < 48), (b == 47));
      end
      if (cmp_Valid) begin
        ncmp++;
        checks++;
        if (cmp_Vector !== mk(10 + b / 8, b % 8) || cmp_VecID !== 8'(10 + b / 8)) begin
          errors++;
          $display("FAIL full_cmpdata cyc %0d: id %0d want %0d", cyc, cmp_VecID, 10 + b / 8);
        end
      end
      ecnt = done ? 0 : ((b >= 32) ? 4 : b / 8);
      checks++;
      if (ref_Cnt !== 3'(ecnt)) begin
        errors++;
        $display("FAIL full_refcnt cyc %0d: got %0d want %0d", cyc, ref_Cnt, ecnt);
      end
      checks++;
      if (batch_Done !== (b == 48 && !done) || busy !== (b > 0 && !done) ||
          up_Ready !== (b < 48 || done)) begin
        errors++;
        $display("FAIL full_ctl cyc %0d: done=%b busy=%b rdy=%b want %b %b %b", cyc,
                 batch_Done, busy, up_Ready, (b == 48 && !done), (b > 0 && !done),
                 (b < 48 || done));
      end
      if (b == 48) done = 1'b1;
      if (b < 48) begin
        prev = (b < 32) ? b : -1;
        b++;
      end else begin
        prev = -1;
      end
    end
    checks++;
    if (npulse != 32 || ncmp != 16) begin
      errors++;
      $display("FAIL full_totals: wr pulses %0d want 32, cmp beats %0d want 16", npulse, ncmp);
    end
  endtask

  // Two vectors, up_Last on beat 16: no query phase.
  task automatic test_short_batch();
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      set_beat(1'b1, 20 + b / 8, b % 8, b == 15);
      #2;
      checks++;
      if (cmp_Valid !== 1'b0 || up_Ready !== 1'b1) begin
        errors++;
        $display("FAIL short_load beat %0d: valid=%b rdy=%b want 0 1", b, cmp_Valid, up_Ready);
      end
    end
    @(negedge clk);
    set_beat(1'b0, 0, 0, 1'b0);
    #2;
    checks++;
    if (ref_Cnt !== 3'd2 || batch_Done !== 1'b1 || ref_WrEn !== 4'b0010 || cmp_Valid !== 1'b0) begin
      errors++;
      $display("FAIL short_drain: cnt=%0d done=%b wren=%b valid=%b want 2 1 0010 0",
               ref_Cnt, batch_Done, ref_WrEn, cmp_Valid);
    end
    @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || batch_Done !== 1'b0 || ref_Cnt !== 3'd0 || up_Ready !== 1'b1) begin
      errors++;
      $display("FAIL short_idle: busy=%b done=%b cnt=%0d rdy=%b want 0 0 0 1",
               busy, batch_Done, ref_Cnt, up_Ready);
    end
  endtask

  // cmp_Ready[2] toggles every cycle during the query phase.
  task automatic test_ready_toggle();
    int q;
    logic erdy;
    cmp_Ready = 4'hF;
    load_refs(30);
    q = 0;
    for (int cyc = 0; cyc < 60 && q < 16; cyc++) begin
      @(negedge clk);
      cmp_Ready = {1'b1, (cyc % 2 == 1), 2'b11};
      set_beat(1'b1, 34 + q / 8, q % 8, q == 15);
      #2;
      erdy = (cyc % 2 == 1);
      checks++;
      if (up_Ready !== erdy || cmp_Valid !== erdy) begin
        errors++;
        $display("FAIL toggle_gate cyc %0d: rdy=%b valid=%b want %b", cyc, up_Ready, cmp_Valid,
                 erdy);
      end
      checks++;
      if (cmp_Last !== (erdy && q == 15)) begin
        errors++;
        $display("FAIL toggle_last cyc %0d: got %b want %b", cyc, cmp_Last, (erdy && q == 15));
      end
      if (erdy) begin
        checks++;
        if (cmp_Vector !== mk(34 + q / 8, q % 8) || cmp_VecID !== 8'(34 + q / 8)) begin
          errors++;
          $display("FAIL toggle_order q %0d: id %0d want %0d", q, cmp_VecID, 34 + q / 8);
        end
        q++;
      end
    end
    @(negedge clk);
    set_beat(1'b0, 0, 0, 1'b0);
    cmp_Ready = 4'hF;
    #2;
    checks++;
    if (batch_Done !== 1'b1 || busy !== 1'b1 || up_Ready !== 1'b0) begin
      errors++;
      $display("FAIL toggle_drain: done=%b busy=%b rdy=%b want 1 1 0", batch_Done, busy, up_Ready);
    end
    @(negedge clk);
  endtask

  // up_Last on sub-vector 3 of a query; the next batch restarts at unit 0, sub 0.
  task automatic test_last_mid_vector();
    cmp_Ready = 4'hF;
    load_refs(40);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      set_beat(1'b1, 44, s, s == 3);
      #2;
      checks++;
      if (cmp_Valid !== 1'b1 || cmp_Last !== (s == 3)) begin
        errors++;
        $display("FAIL mid_query sub %0d: valid=%b last=%b want 1 %b", s, cmp_Valid, cmp_Last,
                 (s == 3));
      end
    end
    @(negedge clk);
    set_beat(1'b0, 0, 0, 1'b0);
    #2;
    checks++;
    if (batch_Done !== 1'b1 || up_Ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain: done=%b rdy=%b want 1 0", batch_Done, up_Ready);
    end
    @(negedge clk);
    set_beat(1'b1, 50, 0, 1'b0);
    #2;
    checks++;
    if (busy !== 1'b0 || up_Ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_idle: busy=%b rdy=%b want 0 1", busy, up_Ready);
    end
    @(negedge clk);
    set_beat(1'b1, 50, 1, 1'b1);
    #2;
    checks++;
    if (ref_WrEn !== 4'b0001 || ref_SubIdx !== 3'd0 || ref_Vector !== mk(50, 0)) begin
      errors++;
      $display("FAIL mid_restart0: wren=%b sub=%0d want 0001 0", ref_WrEn, ref_SubIdx);
    end
    @(negedge clk);
    set_beat(1'b0, 0, 0, 1'b0);
    #2;
    checks++;
    if (ref_WrEn !== 4'b0001 || ref_SubIdx !== 3'd1 || batch_Done !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart1: wren=%b sub=%0d done=%b want 0001 1 1",
               ref_WrEn, ref_SubIdx, batch_Done);
    end
    @(negedge clk);
  endtask

  // One-cycle reset while unit 2, sub 5 is being loaded.
  task automatic test_reset_mid_load();
    cmp_Ready = 4'hF;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      set_beat(1'b1, 60 + i / 8, i % 8, 1'b0);
    end
    @(negedge clk);
    set_beat(1'b1, 62, 5, 1'b0);
    rstn = 1'b0;
    #2;
    checks++;
    if (ref_WrEn !== 4'b0100 || ref_SubIdx !== 3'd4 || ref_Cnt !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_pre: wren=%b sub=%0d cnt=%0d want 0100 4 2",
               ref_WrEn, ref_SubIdx, ref_Cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    set_beat(1'b0, 0, 0, 1'b0);
    #2;
    checks++;
    if (ref_WrEn !== 4'h0 || ref_Vector !== '0 || ref_SubIdx !== 3'd0 || ref_Cnt !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_ref: wren=%b sub=%0d cnt=%0d want zeros", ref_WrEn, ref_SubIdx,
               ref_Cnt);
    end
    checks++;
    if (busy !== 1'b0 || up_Ready !== 1'b1 || batch_Done !== 1'b0 || cmp_Valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ctl: busy=%b rdy=%b done=%b valid=%b want 0 1 0 0",
               busy, up_Ready, batch_Done, cmp_Valid);
    end
    @(negedge clk);
    set_beat(1'b1, 70, 0, 1'b0);
    @(negedge clk);
    set_beat(1'b1, 70, 1, 1'b1);
    #2;
    checks++;
    if (ref_WrEn !== 4'b0001 || ref_SubIdx !== 3'd0 || ref_Vector !== mk(70, 0)) begin
      errors++;
      $display("FAIL rstmid_reload: wren=%b sub=%0d want 0001 0", ref_WrEn, ref_SubIdx);
    end
    @(negedge clk);
    set_beat(1'b0, 0, 0, 1'b0);
    #2;
    checks++;
    if (batch_Done !== 1'b1 || ref_WrEn !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_end: done=%b wren=%b want 1 0001", batch_Done, ref_WrEn);
    end
    @(negedge clk);
  endtask

  // DRAIN held off by cmp_Ready for 10 cycles.
  task automatic test_drain_stall();
    cmp_Ready = 4'h0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      set_beat(1'b1, 80, s, s == 7);
      #2;
      checks++;
      if (up_Ready !== 1'b1) begin
        errors++;
        $display("FAIL stall_load sub %0d: rdy=%b want 1", s, up_Ready);
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      set_beat(1'b0, 0, 0, 1'b0);
      cmp_Ready = (k < 5) ? 4'h0 : 4'b1011;
      #2;
      checks++;
      if (up_Ready !== 1'b0 || batch_Done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_wait k %0d: rdy=%b done=%b busy=%b want 0 0 1",
                 k, up_Ready, batch_Done, busy);
      end
    end
    @(negedge clk);
    cmp_Ready = 4'hF;
    #2;
    checks++;
    if (batch_Done !== 1'b1 || ref_Cnt !== 3'd1 || up_Ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: done=%b cnt=%0d rdy=%b want 1 1 0",
               batch_Done, ref_Cnt, up_Ready);
    end
    @(negedge clk);
    #2;
    checks++;
    if (batch_Done !== 1'b0 || busy !== 1'b0 || up_Ready !== 1'b1 || ref_Cnt !== 3'd0) begin
      errors++;
      $display("FAIL stall_idle: done=%b busy=%b rdy=%b cnt=%0d want 0 0 1 0",
               batch_Done, busy, up_Ready, ref_Cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_batch();
    test_short_batch();
    test_ready_toggle();
    test_last_mid_vector();
    test_reset_mid_load();
    test_drain_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_sched.md
# cmp_sched

Batch scheduler between the sub-vector separator and the array of UNIT_NO comparator units. It consumes the separated sub-vector stream (one vector per word group, with ID and batch-last). The first UNIT_NO vectors of each batch are steered as reference vectors into the units, one unit per vector. Every following vector is broadcast to all units as a query until batch-last, after which the block drains and signals batch completion.

## Interface
- BUS_WIDTH, 128, sub-vector word width
- VECTOR_WIDTH, 920, fingerprint width in bits
- VEC_ID_WIDTH, 8, vector ID width
- UNIT_NO, 4, number of comparator units (≥1)
- SUB_VEC_NO, ceil(VECTOR_WIDTH/BUS_WIDTH), sub-vectors per vector (≥2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- up_Vector  in  BUS_WIDTH  sub-vector from separator
- up_VecID  in  VEC_ID_WIDTH  ID of current vector
- up_Valid  in  1  up_Vector valid
- up_Last  in  1  last sub-vector of the batch
- up_Ready  out  1  beat accepted when up_Valid && up_Ready
- ref_Vector  out  BUS_WIDTH  registered reference sub-vector
- ref_SubIdx  out  $clog2(SUB_VEC_NO)  sub-vector index within the reference vector
- ref_WrEn  out  UNIT_NO  one-hot write strobe, bit k targets unit k
- cmp_Vector  out  BUS_WIDTH  broadcast query sub-vector
- cmp_VecID  out  VEC_ID_WIDTH  query vector ID
- cmp_Valid  out  1  broadcast transfer strobe
- cmp_Last  out  1  last query sub-vector of the batch
- cmp_Ready  in  UNIT_NO  per-unit ready
- ref_Cnt  out  $clog2(UNIT_NO+1)  number of units loaded in the current batch
- batch_Done  out  1  one-cycle pulse at batch end
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, COMPARE, DRAIN.
- Counters:
  - r_SubCntr (0..SUB_VEC_NO-1): advances on every accepted beat; wraps at SUB_VEC_NO-1.
  - r_UnitSel (0..UNIT_NO-1): advances when r_SubCntr wraps in LOAD.
- IDLE:
  - up_Ready=1.
  - On an accepted beat, go to LOAD and treat the beat as a LOAD beat (sub 0, unit 0).
- LOAD:
  - up_Ready=1.
  - Each accepted beat writes ref_Vector=up_Vector, ref_SubIdx=r_SubCntr, ref_WrEn=1<<r_UnitSel.
  - On the beat with r_SubCntr=SUB_VEC_NO-1, ref_Cnt increments.
  - If r_UnitSel=UNIT_NO-1 on that beat, go to COMPARE.
- COMPARE:
  - up_Ready = &cmp_Ready.
  - cmp_Valid = up_Valid && (&cmp_Ready); units sample only on cmp_Valid.
  - cmp_Vector, cmp_VecID and cmp_Last pass through combinationally; cmp_Last = up_Last && cmp_Valid.
- Batch end: an accepted beat with up_Last in LOAD or COMPARE goes to DRAIN.
  - r_SubCntr and r_UnitSel clear regardless of alignment; up_Last always ends the vector.
- DRAIN:
  - up_Ready=0.
  - When &cmp_Ready=1, pulse batch_Done for one cycle, clear ref_Cnt, go to IDLE.
- Short batch (up_Last in LOAD): no query phase. ref_Cnt holds the loaded count until the DRAIN exit, so units ≥ ref_Cnt are ignored downstream.
- ref_Cnt saturates at UNIT_NO.

## Timing
- Reset values:
  - state=IDLE, counters=0.
  - ref_WrEn=0, ref_Vector=0, ref_SubIdx=0, ref_Cnt=0.
  - batch_Done=0, busy=0.
  - up_Ready=1.
  - cmp_Valid=0, cmp_Last=0.
- Reset mid-batch: all state returns to reset values on the next edge. No partial ref write is emitted after the reset edge.
- Reference path latency: 1 cycle. ref_* are registered, and ref_WrEn is asserted exactly one cycle per accepted LOAD beat.
- Compare path latency: 0 cycles (combinational). No beat is lost or duplicated when cmp_Ready bits deassert independently.
- LOAD→COMPARE is effective from the cycle after the final reference beat. Consecutive up_Valid beats sustain 1 beat/cycle throughout.
- DRAIN lasts at least 1 cycle. batch_Done is asserted in the DRAIN exit cycle. up_Ready stays 0 until the following cycle (IDLE).
- up_Last and the final reference beat in the same cycle: DRAIN takes priority over COMPARE.

## Structure
- Shared package holds:
  - state encoding localparams (IDLE=0, LOAD=1, COMPARE=2, DRAIN=3);
  - the SUB_VEC_NO ceil-div function;
  - width helpers for ref_SubIdx and ref_Cnt.
- One sub-module: cmp_sched_ctr, a parameterized wrap counter (max value, enable, clear, wrap flag). It is instantiated twice, for r_SubCntr and r_UnitSel.

## Test plan
- UNIT_NO=4, SUB_VEC_NO=8, 6 vectors, continuous valid:
  - 32 ref_WrEn pulses, 8 per unit, in order 0001…1000;
  - then 16 cmp_Valid beats, with cmp_Last on beat 48;
  - batch_Done one cycle after, once all cmp_Ready are high.
- Short batch, 2 vectors with up_Last on beat 16: ref_Cnt=2, no cmp_Valid, batch_Done pulse, state returns to IDLE.
- COMPARE with cmp_Ready[2] toggling 0/1 every cycle:
  - up_Ready and cmp_Valid are gated identically;
  - each query sub-vector is broadcast exactly once, and output order matches input order.
- up_Last on sub-vector 3 of a query vector: DRAIN entered; the next batch starts at sub 0, unit 0.
- rstn low for 1 cycle mid-LOAD (unit 2, sub 5): all outputs at reset values next cycle; a new batch reloads from unit 0.
- DRAIN with cmp_Ready=0 for 10 cycles: up_Ready stays 0 and batch_Done stays 0; batch_Done pulses in the cycle cmp_Ready becomes all-ones.
